// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, R-type function codes,
// ALU-control encodings and the control bundle carried down the pipeline.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic       zeroimm;
    logic [2:0] alucontrol;
    logic       branch;
    logic       bne;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Returns {valid, alu_op} for an R-type function field.
  function automatic logic [3:0] rtype_alu(input logic [5:0] funct);
    logic [3:0] res;
    case (funct)
      FN_ADD:  res = {1'b1, ALU_ADD};
      FN_SUB:  res = {1'b1, ALU_SUB};
      FN_AND:  res = {1'b1, ALU_AND};
      FN_OR:   res = {1'b1, ALU_OR};
      FN_SLT:  res = {1'b1, ALU_SLT};
      default: res = {1'b0, ALU_AND};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational D-stage decoder: op/funct to control bundle plus an
// illegal-instruction flag. Unrecognised encodings yield a NOP bundle.
module ctrl_decode
  import mips_pkg::*;
#(
  parameter int EXT_OPS = 1
) (
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  localparam bit EXT_EN = (EXT_OPS != 0);

  ctrl_t      w_raw;
  logic       w_illegal;
  logic [3:0] w_rtype;

  assign w_rtype = rtype_alu(i_funct);

  // Opcode decode into a raw bundle and illegal flag.
  always_comb begin
    w_raw     = CTRL_NOP;
    w_illegal = 1'b0;
    case (i_op)
      OP_LW: begin
        w_raw.regwrite   = 1'b1;
        w_raw.memtoreg   = 1'b1;
        w_raw.alusrc     = 1'b1;
        w_raw.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        w_raw.memwrite   = 1'b1;
        w_raw.alusrc     = 1'b1;
        w_raw.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        w_raw.branch     = 1'b1;
        w_raw.alucontrol = ALU_SUB;
      end
      OP_BNE: begin
        if (EXT_EN) begin
          w_raw.branch     = 1'b1;
          w_raw.bne        = 1'b1;
          w_raw.alucontrol = ALU_SUB;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        if (EXT_EN) begin
          w_raw.regwrite = 1'b1;
          w_raw.alusrc   = 1'b1;
          w_raw.zeroimm  = (i_op == OP_ANDI) || (i_op == OP_ORI);
          case (i_op)
            OP_ANDI: w_raw.alucontrol = ALU_AND;
            OP_ORI:  w_raw.alucontrol = ALU_OR;
            OP_SLTI: w_raw.alucontrol = ALU_SLT;
            default: w_raw.alucontrol = ALU_ADD;
          endcase
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_RTYPE: begin
        if (w_rtype[3]) begin
          w_raw.regwrite   = 1'b1;
          w_raw.regdst     = 1'b1;
          w_raw.alucontrol = w_rtype[2:0];
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_J: begin
        w_raw.jump = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign o_ctrl    = w_illegal ? CTRL_NOP : w_raw;
  assign o_illegal = w_illegal;

endmodule

// File: rtl/pipe_controller.sv
// Pipelined MIPS control unit: decodes in D and carries each instruction's
// control through the ID/EX, EX/MEM and MEM/WB control registers.
module pipe_controller
  import mips_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int EXT_OPS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 equal_d,
  input  logic                 flush_e,
  output logic                 pcsrc_d,
  output logic                 jump_d,
  output logic                 illegal_d,
  output logic                 regwrite_e,
  output logic                 memtoreg_e,
  output logic                 memwrite_e,
  output logic                 alusrc_e,
  output logic                 regdst_e,
  output logic                 zeroimm_e,
  output logic [ALUCTRL_W-1:0] alucontrol_e,
  output logic                 regwrite_m,
  output logic                 memtoreg_m,
  output logic                 memwrite_m,
  output logic                 regwrite_w,
  output logic                 memtoreg_w
);

  ctrl_t w_ctrl_d;
  logic  w_illegal_d;

  logic                 r_regwrite_e, r_memtoreg_e, r_memwrite_e;
  logic                 r_alusrc_e, r_regdst_e, r_zeroimm_e;
  logic [ALUCTRL_W-1:0] r_alucontrol_e;
  logic                 r_regwrite_m, r_memtoreg_m, r_memwrite_m;
  logic                 r_regwrite_w, r_memtoreg_w;

  ctrl_decode #(.EXT_OPS(EXT_OPS)) u_decode (
    .i_op      (op),
    .i_funct   (funct),
    .o_ctrl    (w_ctrl_d),
    .o_illegal (w_illegal_d)
  );

  // bne inverts the sense of the register compare.
  assign pcsrc_d   = w_ctrl_d.branch & (w_ctrl_d.bne ? ~equal_d : equal_d);
  assign jump_d    = w_ctrl_d.jump;
  assign illegal_d = w_illegal_d;

  // ID/EX control register; a flush inserts a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regwrite_e   <= 1'b0;
      r_memtoreg_e   <= 1'b0;
      r_memwrite_e   <= 1'b0;
      r_alusrc_e     <= 1'b0;
      r_regdst_e     <= 1'b0;
      r_zeroimm_e    <= 1'b0;
      r_alucontrol_e <= '0;
    end else if (flush_e) begin
      r_regwrite_e   <= 1'b0;
      r_memtoreg_e   <= 1'b0;
      r_memwrite_e   <= 1'b0;
      r_alusrc_e     <= 1'b0;
      r_regdst_e     <= 1'b0;
      r_zeroimm_e    <= 1'b0;
      r_alucontrol_e <= '0;
    end else begin
      r_regwrite_e   <= w_ctrl_d.regwrite;
      r_memtoreg_e   <= w_ctrl_d.memtoreg;
      r_memwrite_e   <= w_ctrl_d.memwrite;
      r_alusrc_e     <= w_ctrl_d.alusrc;
      r_regdst_e     <= w_ctrl_d.regdst;
      r_zeroimm_e    <= w_ctrl_d.zeroimm;
      r_alucontrol_e <= ALUCTRL_W'(w_ctrl_d.alucontrol);
    end
  end

  // EX/MEM and MEM/WB control registers always advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regwrite_m <= 1'b0;
      r_memtoreg_m <= 1'b0;
      r_memwrite_m <= 1'b0;
      r_regwrite_w <= 1'b0;
      r_memtoreg_w <= 1'b0;
    end else begin
      r_regwrite_m <= r_regwrite_e;
      r_memtoreg_m <= r_memtoreg_e;
      r_memwrite_m <= r_memwrite_e;
      r_regwrite_w <= r_regwrite_m;
      r_memtoreg_w <= r_memtoreg_m;
    end
  end

  assign regwrite_e   = r_regwrite_e;
  assign memtoreg_e   = r_memtoreg_e;
  assign memwrite_e   = r_memwrite_e;
  assign alusrc_e     = r_alusrc_e;
  assign regdst_e     = r_regdst_e;
  assign zeroimm_e    = r_zeroimm_e;
  assign alucontrol_e = r_alucontrol_e;
  assign regwrite_m   = r_regwrite_m;
  assign memtoreg_m   = r_memtoreg_m;
  assign memwrite_m   = r_memwrite_m;
  assign regwrite_w   = r_regwrite_w;
  assign memtoreg_w   = r_memtoreg_w;

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: a 5-bit ALU-control instance with
// extended ops, plus a base instance with extended ops disabled.
module tb_pipe_controller;

  typedef struct packed {
    logic       rw, mtr, mw, as, rd, zi;
    logic [2:0] alu;
    logic       br, bn, j, ill;
  } tb_ctrl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       equal_d, flush_e;

  logic       pcsrc_d, jump_d, illegal_d;
  logic       regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, zeroimm_e;
  logic [4:0] alucontrol_e;
  logic       regwrite_m, memtoreg_m, memwrite_m, regwrite_w, memtoreg_w;

  logic       b_pcsrc_d, b_jump_d, b_illegal_d;
  logic       b_regwrite_e, b_memtoreg_e, b_memwrite_e, b_alusrc_e, b_regdst_e, b_zeroimm_e;
  logic [2:0] b_alucontrol_e;
  logic       b_regwrite_m, b_memtoreg_m, b_memwrite_m, b_regwrite_w, b_memtoreg_w;

  int n_checks = 0;
  int n_fail   = 0;

  tb_ctrl_t q_e[$];
  tb_ctrl_t q_m[$];
  tb_ctrl_t q_w[$];

  always #5 clk = ~clk;

  pipe_controller #(.ALUCTRL_W(5), .EXT_OPS(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .equal_d(equal_d), .flush_e(flush_e),
    .pcsrc_d(pcsrc_d), .jump_d(jump_d), .illegal_d(illegal_d),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
    .alusrc_e(alusrc_e), .regdst_e(regdst_e), .zeroimm_e(zeroimm_e), .alucontrol_e(alucontrol_e),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .memwrite_m(memwrite_m),
    .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w)
  );

  pipe_controller #(.ALUCTRL_W(3), .EXT_OPS(0)) dut_base (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .equal_d(equal_d), .flush_e(flush_e),
    .pcsrc_d(b_pcsrc_d), .jump_d(b_jump_d), .illegal_d(b_illegal_d),
    .regwrite_e(b_regwrite_e), .memtoreg_e(b_memtoreg_e), .memwrite_e(b_memwrite_e),
    .alusrc_e(b_alusrc_e), .regdst_e(b_regdst_e), .zeroimm_e(b_zeroimm_e), .alucontrol_e(b_alucontrol_e),
    .regwrite_m(b_regwrite_m), .memtoreg_m(b_memtoreg_m), .memwrite_m(b_memwrite_m),
    .regwrite_w(b_regwrite_w), .memtoreg_w(b_memtoreg_w)
  );

  logic [15:0] all_regs;
  assign all_regs = {regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, zeroimm_e,
                     alucontrol_e, regwrite_m, memtoreg_m, memwrite_m, regwrite_w, memtoreg_w};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic tb_ctrl_t model(input logic [5:0] o, input logic [5:0] f, input bit ext);
    tb_ctrl_t m;
    m = '0;
    if (o == 6'b100011) begin
      m.rw = 1'b1; m.mtr = 1'b1; m.as = 1'b1; m.alu = 3'b010;
    end else if (o == 6'b101011) begin
      m.mw = 1'b1; m.as = 1'b1; m.alu = 3'b010;
    end else if (o == 6'b000100) begin
      m.br = 1'b1; m.alu = 3'b110;
    end else if (ext && o == 6'b000101) begin
      m.br = 1'b1; m.bn = 1'b1; m.alu = 3'b110;
    end else if (ext && o == 6'b001000) begin
      m.rw = 1'b1; m.as = 1'b1; m.alu = 3'b010;
    end else if (ext && o == 6'b001100) begin
      m.rw = 1'b1; m.as = 1'b1; m.zi = 1'b1; m.alu = 3'b000;
    end else if (ext && o == 6'b001101) begin
      m.rw = 1'b1; m.as = 1'b1; m.zi = 1'b1; m.alu = 3'b001;
    end else if (ext && o == 6'b001010) begin
      m.rw = 1'b1; m.as = 1'b1; m.alu = 3'b111;
    end else if (o == 6'b000010) begin
      m.j = 1'b1;
    end else if (o == 6'b000000) begin
      m.rw = 1'b1; m.rd = 1'b1;
      if      (f == 6'b100000) m.alu = 3'b010;
      else if (f == 6'b100010) m.alu = 3'b110;
      else if (f == 6'b100100) m.alu = 3'b000;
      else if (f == 6'b100101) m.alu = 3'b001;
      else if (f == 6'b101010) m.alu = 3'b111;
      else m.ill = 1'b1;
    end else begin
      m.ill = 1'b1;
    end
    if (m.ill) m = tb_ctrl_t'(13'b0000000000001);
    return m;
  endfunction

  function automatic logic exp_pcsrc(input tb_ctrl_t m, input logic eq);
    return m.br & (m.bn ? ~eq : eq);
  endfunction

  task automatic reinit_queues();
    q_e.delete(); q_m.delete(); q_w.delete();
    q_m.push_back('0);
    q_w.push_back('0);
  endtask

  // Drive one D-stage instruction, check D outputs, clock it in and check E/M/W.
  task automatic step(input string name, input logic [5:0] o, input logic [5:0] f,
                      input logic eq, input logic fl);
    tb_ctrl_t m, mb, it, mi, wi;
    op = o; funct = f; equal_d = eq; flush_e = fl;
    #1;
    m  = model(o, f, 1'b1);
    mb = model(o, f, 1'b0);
    check_val({name, ".pcsrc_d"},   32'(pcsrc_d),     32'(exp_pcsrc(m, eq)));
    check_val({name, ".jump_d"},    32'(jump_d),      32'(m.j));
    check_val({name, ".illegal_d"}, 32'(illegal_d),   32'(m.ill));
    check_val({name, ".base_ill"},  32'(b_illegal_d), 32'(mb.ill));
    check_val({name, ".base_pcs"},  32'(b_pcsrc_d),   32'(exp_pcsrc(mb, eq)));
    q_e.push_back(fl ? tb_ctrl_t'(13'b0) : m);
    @(posedge clk);
    #1;
    it = q_e.pop_front();
    mi = q_m.pop_front();
    wi = q_w.pop_front();
    check_val({name, ".e"},
              32'({regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, zeroimm_e, alucontrol_e}),
              32'({it.rw, it.mtr, it.mw, it.as, it.rd, it.zi, 2'b00, it.alu}));
    check_val({name, ".m"}, 32'({regwrite_m, memtoreg_m, memwrite_m}), 32'({mi.rw, mi.mtr, mi.mw}));
    check_val({name, ".w"}, 32'({regwrite_w, memtoreg_w}), 32'({wi.rw, wi.mtr}));
    q_m.push_back(it);
    q_w.push_back(mi);
  endtask

  initial begin
    reset = 1'b1; op = 6'b000000; funct = 6'b000000; equal_d = 1'b0; flush_e = 1'b0;
    #12;
    check_val("reset.regs", 32'(all_regs), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    reinit_queues();

    step("lw",        6'b100011, 6'b000000, 1'b0, 1'b0);
    step("sw_flush",  6'b101011, 6'b000000, 1'b0, 1'b1);
    step("beq_eq",    6'b000100, 6'b000000, 1'b1, 1'b0);
    step("beq_ne",    6'b000100, 6'b000000, 1'b0, 1'b0);
    step("bne_ne",    6'b000101, 6'b000000, 1'b0, 1'b0);
    step("bne_eq",    6'b000101, 6'b000000, 1'b1, 1'b0);
    step("andi",      6'b001100, 6'b000000, 1'b0, 1'b0);
    step("addi",      6'b001000, 6'b000000, 1'b0, 1'b0);
    step("slt",       6'b000000, 6'b101010, 1'b0, 1'b0);
    step("sub",       6'b000000, 6'b100010, 1'b0, 1'b0);
    step("and",       6'b000000, 6'b100100, 1'b0, 1'b0);
    step("or",        6'b000000, 6'b100101, 1'b0, 1'b0);
    step("ori",       6'b001101, 6'b000000, 1'b0, 1'b0);
    step("slti",      6'b001010, 6'b000000, 1'b0, 1'b0);
    step("sw",        6'b101011, 6'b000000, 1'b0, 1'b0);
    step("j",         6'b000010, 6'b000000, 1'b1, 1'b0);
    step("ill_op",    6'b111111, 6'b100000, 1'b1, 1'b0);
    step("ill_fn",    6'b000000, 6'b000000, 1'b0, 1'b0);
    step("lw_flush",  6'b100011, 6'b000000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [5:0] rop;
      logic [5:0] rfn;
      rop = 6'($urandom_range(0, 63));
      rfn = 6'($urandom_range(0, 63));
      step("rand", rop, rfn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    step("pre_lw1",   6'b100011, 6'b000000, 1'b0, 1'b0);
    step("pre_add",   6'b000000, 6'b100000, 1'b0, 1'b0);
    step("pre_lw2",   6'b100011, 6'b000000, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_val("midreset.async", 32'(all_regs), 32'h0);
    @(posedge clk); #1;
    check_val("midreset.hold", 32'(all_regs), 32'h0);
    reset = 1'b0;
    reinit_queues();
    step("post_lw",   6'b100011, 6'b000000, 1'b0, 1'b0);
    step("post_add",  6'b000000, 6'b100000, 1'b0, 1'b0);
    step("post_sw",   6'b101011, 6'b000000, 1'b0, 1'b0);
    step("drain1",    6'b000010, 6'b000000, 1'b0, 1'b0);
    step("drain2",    6'b000010, 6'b000000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_controller.md
# pipe_controller

Pipelined control unit for the five-stage MIPS core. It decodes `op`/`funct` in the Decode stage and produces the control bundle for that instruction. It carries the bundle through the ID/EX, EX/MEM and MEM/WB control registers, so each stage sees the control belonging to its own instruction. Compared with the single-cycle decoder, it adds:
- `bne` and the immediate ALU ops;
- a parametrised ALU-control width;
- a flush input from the hazard unit;
- illegal-instruction detection.

## Interface
Parameters:
- `ALUCTRL_W`, default 3: width of `alucontrol_e`; encodings are zero-extended into it; must be ≥ 3.
- `EXT_OPS`, default 1: when 1, enables `bne`, `addi`, `andi`, `ori` and `slti`; when 0, these decode as illegal.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock; all registers update on the rising edge.
- `reset` in 1: asynchronous, active-high; clears every pipeline control register.
- `op` in 6: D-stage opcode.
- `funct` in 6: D-stage function field.
- `equal_d` in 1: register-compare result from D.
- `flush_e` in 1: hazard unit; loads NOP into the ID/EX control register.
- `pcsrc_d` out 1: take branch.
- `jump_d` out 1: jump.
- `illegal_d` out 1: current D instruction is not recognised.
- `regwrite_e`, `memtoreg_e`, `memwrite_e`, `alusrc_e`, `regdst_e`, `zeroimm_e` out 1 each.
- `alucontrol_e` out `ALUCTRL_W`.
- `regwrite_m`, `memtoreg_m`, `memwrite_m` out 1 each.
- `regwrite_w`, `memtoreg_w` out 1 each.

## Operation
- **Opcodes:** R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, slti 001010, j 000010.
- **ALU encodings:** and 000, or 001, add 010, sub 110, slt 111.
- **R-type funct:** 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct is illegal.
- **Decoded bundles:**
  - lw: regwrite, memtoreg, alusrc, add.
  - sw: memwrite, alusrc, add.
  - beq and bne: sub, no writes.
  - addi, andi, ori, slti: regwrite, alusrc, ALU op add/and/or/slt respectively; andi and ori also set zeroimm.
  - R-type: regwrite, regdst, ALU op from funct.
  - j: jump only.
- **Illegal instructions:** `illegal_d`=1; the bundle is forced to all-zero (NOP); `pcsrc_d`=0 and `jump_d`=0.
- **Branch:** `pcsrc_d` = (beq & `equal_d`) | (bne & ~`equal_d`), combinational in D.
- **ID/EX register:**
  - On a clock edge with `flush_e`=1, it loads all-zero, regardless of `op`.
  - Otherwise it loads the D bundle.
- **EX/MEM and MEM/WB registers:** always advance; they have no stall or flush of their own.
- **Reset:** all registered outputs are 0 immediately on `reset` assertion, and they stay 0 while reset is held. The D-stage outputs (`pcsrc_d`, `jump_d`, `illegal_d`) remain combinational functions of the inputs during reset.

## Timing
- **D outputs:** zero latency (combinational from `op`, `funct`, `equal_d`).
- **Stage latency:** `_e` outputs are valid one edge after the instruction is in D, `_m` two edges after, `_w` three edges after.
- **flush_e with a new decode:** when `flush_e` and a new decode occur in the same cycle, the flush wins for ID/EX. The same cycle's M and W still advance normally.
- **Reset deassertion:** the first edge after deassertion loads the current D bundle, unless `flush_e` is asserted.
- **NOP propagation:** a flushed bubble carries regwrite=0 and memwrite=0 through M and W. This guarantees no architectural side effects.

## Structure
- Shared package `mips_pkg` holds:
  - opcode and funct localparams;
  - ALU-control encodings as 3-bit constants;
  - packed struct `ctrl_t` with fields regwrite, memtoreg, memwrite, alusrc, regdst, zeroimm, alucontrol, branch, bne, jump;
  - constant `CTRL_NOP` = '0.
- Sub-module `ctrl_decode`: purely combinational decode of op/funct/`EXT_OPS` into `ctrl_t` plus `illegal`.
- `pipe_controller` contains:
  - `ctrl_decode`;
  - the `pcsrc` logic;
  - three registers holding `ctrl_t`, or a subset per stage.

## Test plan
- **lw through the pipe:** reset, then present op=100011.
  - `_e` shows regwrite=1, memtoreg=1, alusrc=1, alucontrol=010 one edge later.
  - `regwrite_m` and `memtoreg_m` = 1 one edge after that.
  - `regwrite_w` and `memtoreg_w` = 1 one edge after that.
- **Branch selection:** beq with `equal_d`=1 → `pcsrc_d`=1; with `equal_d`=0 → 0. bne with `equal_d`=0 → 1; with `equal_d`=1 → 0. With `EXT_OPS`=0, bne → `illegal_d`=1 and `pcsrc_d`=0.
- **Flush:** sw in D with `flush_e`=1 → `memwrite_e`=0 after the edge, and `memwrite_m`=0 on the next edge. The prior instruction's `_m` still shows its own values.
- **Immediates and R-type:** andi → `zeroimm_e`=1, `alucontrol_e`=000. addi → `zeroimm_e`=0, alucontrol=010. R-type funct 101010 → alucontrol=111, regdst=1.
- **Illegal:** op=111111, or R-type funct=000000 → `illegal_d`=1, and all `_e` outputs = 0 after the edge.
- **Reset mid-stream:** assert `reset` asynchronously with lw/R-type instructions in E, M and W → all `_e`, `_m` and `_w` outputs drop to 0 before the next edge. With `ALUCTRL_W`=5, upper bits of `alucontrol_e` are always 0.
